// File: rtl/pbvi_pkg.sv
`default_nettype none
// ============================================================================
// pbvi_pkg : shared types, FSM encoding and width helpers for the PBVI engine
// Revision : 1.0
// ============================================================================
package pbvi_pkg;

    localparam int c_def_n_state = 2;
    localparam int c_def_data_w  = 16;
    localparam int c_def_act_w   = 2;

    typedef logic [c_def_n_state-1:0][c_def_data_w-1:0] belief_t;
    typedef logic [c_def_n_state-1:0][c_def_data_w-1:0] alpha_vec_t;
    typedef logic [c_def_act_w-1:0]                     action_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Full-precision width of an N-term sum of DATA_W x DATA_W products
    function automatic int val_w(input int data_w, input int n_state);
        return 2 * data_w + ((n_state > 1) ? $clog2(n_state) : 0);
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pbvi_argmax_engine_dot.sv
`default_nettype none
// ============================================================================
// pbvi_dot_product : combinational belief . alpha MAC at full precision
// Revision : 1.0
// ============================================================================
module pbvi_dot_product
    import pbvi_pkg::*;
#(
    parameter int N_STATE = 2,
    parameter int DATA_W  = 16,
    parameter int VAL_W   = val_w(DATA_W, N_STATE)
) (
    input  logic [N_STATE-1:0][DATA_W-1:0] belief,
    input  logic [N_STATE-1:0][DATA_W-1:0] alpha_vec,
    output logic [VAL_W-1:0]               value
);

    always_comb begin
        value = '0;
        for (int s = 0; s < N_STATE; s++) begin
            value = value + VAL_W'(belief[s]) * VAL_W'(alpha_vec[s]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/pbvi_argmax_engine.sv
`default_nettype none
// ============================================================================
// pbvi_argmax_engine : time-multiplexed argmax over alpha vectors, LANES/cycle
// Revision : 1.0
// ============================================================================
module pbvi_argmax_engine
    import pbvi_pkg::*;
#(
    parameter int  N_ALPHA = 16,
    parameter int  N_STATE = 2,
    parameter int  DATA_W  = 16,
    parameter int  ACT_W   = 2,
    parameter int  LANES   = 4,
    localparam int VAL_W   = val_w(DATA_W, N_STATE),
    localparam int IDX_W   = idx_w(N_ALPHA)
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       start,
    input  logic                                       clear,
    input  logic [N_STATE-1:0][DATA_W-1:0]             current_belief,
    input  logic [N_ALPHA-1:0][N_STATE-1:0][DATA_W-1:0] alpha,
    input  logic [N_ALPHA-1:0][ACT_W-1:0]              point_action,
    output logic                                       busy,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [ACT_W-1:0]                           out_action,
    output logic [IDX_W-1:0]                           out_index,
    output logic [VAL_W-1:0]                           out_value,
    output logic                                       done_pulse
);

    localparam int c_nb      = (N_ALPHA + LANES - 1) / LANES;
    localparam int c_batch_w = idx_w(c_nb);
    localparam logic [c_batch_w-1:0] c_last_batch = c_batch_w'(c_nb - 1);

    state_t                          state_q, state_d;
    logic [c_batch_w-1:0]            batch_q, batch_d;
    logic [N_STATE-1:0][DATA_W-1:0]  belief_q, belief_d;
    logic [VAL_W-1:0]                best_val_q, best_val_d;
    logic [IDX_W-1:0]                best_idx_q, best_idx_d;
    logic                            first_q, first_d;
    logic [ACT_W-1:0]                out_action_q, out_action_d;
    logic [IDX_W-1:0]                out_index_q, out_index_d;
    logic [VAL_W-1:0]                out_value_q, out_value_d;
    logic                            done_pulse_q, done_pulse_d;

    logic [LANES-1:0][VAL_W-1:0]     w_lane_val;
    logic [LANES-1:0][IDX_W-1:0]     w_lane_idx;
    logic [LANES-1:0]                w_lane_ok;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [31:0]                    w_flat_idx;
        logic [N_STATE-1:0][DATA_W-1:0] w_alpha_sel;

        assign w_flat_idx    = 32'(batch_q) * 32'(LANES) + 32'(l);
        // Lanes past the last vector in a ragged final batch are masked out
        assign w_lane_ok[l]  = (w_flat_idx < 32'(N_ALPHA));
        assign w_lane_idx[l] = IDX_W'(w_flat_idx);
        assign w_alpha_sel   = w_lane_ok[l] ? alpha[w_lane_idx[l]] : '0;

        pbvi_dot_product #(
            .N_STATE (N_STATE),
            .DATA_W  (DATA_W),
            .VAL_W   (VAL_W)
        ) u_dot (
            .belief    (belief_q),
            .alpha_vec (w_alpha_sel),
            .value     (w_lane_val[l])
        );
    end

    logic             w_bat_found;
    logic [VAL_W-1:0] w_bat_val;
    logic [IDX_W-1:0] w_bat_idx;
    logic             w_take;
    logic [VAL_W-1:0] w_new_val;
    logic [IDX_W-1:0] w_new_idx;

    // Strict '>' scanning upward keeps the lowest index on ties
    always_comb begin
        w_bat_found = 1'b0;
        w_bat_val   = '0;
        w_bat_idx   = '0;
        for (int l = 0; l < LANES; l++) begin
            if (w_lane_ok[l] && (!w_bat_found || (w_lane_val[l] > w_bat_val))) begin
                w_bat_found = 1'b1;
                w_bat_val   = w_lane_val[l];
                w_bat_idx   = w_lane_idx[l];
            end
        end
        w_take    = w_bat_found && (first_q || (w_bat_val > best_val_q));
        w_new_val = w_take ? w_bat_val : best_val_q;
        w_new_idx = w_take ? w_bat_idx : best_idx_q;
    end

    always_comb begin
        state_d      = state_q;
        batch_d      = batch_q;
        belief_d     = belief_q;
        best_val_d   = best_val_q;
        best_idx_d   = best_idx_q;
        first_d      = first_q;
        out_action_d = out_action_q;
        out_index_d  = out_index_q;
        out_value_d  = out_value_q;
        done_pulse_d = 1'b0;

        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d    = ST_EVAL;
                        belief_d   = current_belief;
                        batch_d    = '0;
                        best_val_d = '0;
                        best_idx_d = '0;
                        first_d    = 1'b1;
                    end
                end
                ST_EVAL: begin
                    best_val_d = w_new_val;
                    best_idx_d = w_new_idx;
                    first_d    = 1'b0;
                    if (batch_q == c_last_batch) begin
                        state_d      = ST_HOLD;
                        out_value_d  = w_new_val;
                        out_index_d  = w_new_idx;
                        out_action_d = point_action[w_new_idx];
                        done_pulse_d = 1'b1;
                    end else begin
                        batch_d = batch_q + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            batch_q      <= '0;
            belief_q     <= '0;
            best_val_q   <= '0;
            best_idx_q   <= '0;
            first_q      <= 1'b0;
            out_action_q <= '0;
            out_index_q  <= '0;
            out_value_q  <= '0;
            done_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            batch_q      <= batch_d;
            belief_q     <= belief_d;
            best_val_q   <= best_val_d;
            best_idx_q   <= best_idx_d;
            first_q      <= first_d;
            out_action_q <= out_action_d;
            out_index_q  <= out_index_d;
            out_value_q  <= out_value_d;
            done_pulse_q <= done_pulse_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign out_valid  = (state_q == ST_HOLD);
    assign out_action = out_action_q;
    assign out_index  = out_index_q;
    assign out_value  = out_value_q;
    assign done_pulse = done_pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_pbvi_argmax_engine.sv
`default_nettype none
// ============================================================================
// tb_pbvi_argmax_engine : directed self-checking bench (default + ragged DUT)
// Revision : 1.0
// ============================================================================
module tb_pbvi_argmax_engine;

    logic clk;
    logic rst_n;
    logic clear;

    logic                          start, out_ready;
    logic [1:0][15:0]              cur_b;
    logic [15:0][1:0][15:0]        alpha;
    logic [15:0][1:0]              pa;
    logic                          busy, out_valid, done_pulse;
    logic [1:0]                    out_action;
    logic [3:0]                    out_index;
    logic [32:0]                   out_value;

    logic                          start_g, out_ready_g;
    logic [1:0][15:0]              cur_b_g;
    logic [9:0][1:0][15:0]         alpha_g;
    logic [9:0][1:0]               pa_g;
    logic                          busy_g, out_valid_g, done_pulse_g;
    logic [1:0]                    out_action_g;
    logic [3:0]                    out_index_g;
    logic [32:0]                   out_value_g;

    int n_cmp = 0;
    int n_err = 0;

    pbvi_argmax_engine dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
        .current_belief(cur_b), .alpha(alpha), .point_action(pa),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_action(out_action), .out_index(out_index),
        .out_value(out_value), .done_pulse(done_pulse)
    );

    pbvi_argmax_engine #(.N_ALPHA(10), .LANES(4)) dut_g (
        .clk(clk), .rst_n(rst_n), .start(start_g), .clear(clear),
        .current_belief(cur_b_g), .alpha(alpha_g), .point_action(pa_g),
        .busy(busy_g), .out_valid(out_valid_g), .out_ready(out_ready_g),
        .out_action(out_action_g), .out_index(out_index_g),
        .out_value(out_value_g), .done_pulse(done_pulse_g)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one cycle, then count cycles until out_valid (bounded)
    task automatic run_start(input bit rag, output int lat);
        if (rag) start_g = 1'b1; else start = 1'b1;
        step();
        start   = 1'b0;
        start_g = 1'b0;
        lat = 1;
        while (((rag ? out_valid_g : out_valid) == 1'b0) && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic retire();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 16; i++) begin
            alpha[i][0] = 16'(i);
            alpha[i][1] = 16'(i);
            pa[i]       = 2'(i % 4);
        end
    endtask

    int  lat;
    bit  seen;

    initial begin
        rst_n = 1'b0; clear = 1'b0;
        start = 1'b0; out_ready = 1'b0; cur_b = '0; alpha = '0; pa = '0;
        start_g = 1'b0; out_ready_g = 1'b0; cur_b_g = '0; alpha_g = '0; pa_g = '0;
        step();
        step();
        rst_n = 1'b1;
        step();

        check_eq("rst_busy",   64'(busy),       64'd0);
        check_eq("rst_valid",  64'(out_valid),  64'd0);
        check_eq("rst_done",   64'(done_pulse), 64'd0);
        check_eq("rst_action", 64'(out_action), 64'd0);
        check_eq("rst_index",  64'(out_index),  64'd0);
        check_eq("rst_value",  64'(out_value),  64'd0);

        // Distinct maximum at the last vector
        load_ramp();
        cur_b = {16'h4000, 16'h4000};
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq("eval_busy",  64'(busy),      64'd1);
        check_eq("eval_valid", 64'(out_valid), 64'd0);
        lat = 1;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        check_eq("max_latency", 64'(lat),        64'd5);
        check_eq("max_index",   64'(out_index),  64'd15);
        check_eq("max_action",  64'(out_action), 64'd3);
        check_eq("max_value",   64'(out_value),  64'h78000);
        check_eq("max_done",    64'(done_pulse), 64'd1);
        step();
        check_eq("max_done_off", 64'(done_pulse), 64'd0);

        // Backpressure: hold result, ignore start pulses
        for (int k = 0; k < 10; k++) begin
            start = 1'b1;
            step();
            check_eq("bp_valid", 64'(out_valid), 64'd1);
            check_eq("bp_busy",  64'(busy),      64'd1);
            check_eq("bp_index", 64'(out_index), 64'd15);
            check_eq("bp_value", 64'(out_value), 64'h78000);
            check_eq("bp_done",  64'(done_pulse), 64'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        start = 1'b0;
        check_eq("retire_valid", 64'(out_valid), 64'd0);
        check_eq("retire_busy",  64'(busy),      64'd0);
        step();
        check_eq("start_dropped", 64'(busy), 64'd0);

        // Tie between vectors 3 and 9 -> lowest index
        alpha = '0;
        alpha[3][0] = 16'd100; alpha[3][1] = 16'd200;
        alpha[9][0] = 16'd100; alpha[9][1] = 16'd200;
        cur_b = {16'd1, 16'd1};
        run_start(1'b0, lat);
        check_eq("tie_latency", 64'(lat),        64'd5);
        check_eq("tie_index",   64'(out_index),  64'd3);
        check_eq("tie_value",   64'(out_value),  64'd300);
        check_eq("tie_action",  64'(out_action), 64'd3);
        retire();

        // Abort in the second EVAL cycle
        load_ramp();
        cur_b = {16'h4000, 16'h4000};
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        check_eq("clr_busy",  64'(busy),      64'd0);
        check_eq("clr_valid", 64'(out_valid), 64'd0);
        check_eq("clr_index", 64'(out_index), 64'd3);
        check_eq("clr_value", 64'(out_value), 64'd300);
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (out_valid || done_pulse) seen = 1'b1;
            step();
        end
        check_eq("clr_no_result", 64'(seen), 64'd0);
        run_start(1'b0, lat);
        check_eq("restart_latency", 64'(lat),       64'd5);
        check_eq("restart_index",   64'(out_index), 64'd15);
        retire();

        // Full-scale operands
        alpha = '0;
        alpha[7][0] = 16'hFFFF; alpha[7][1] = 16'hFFFF;
        cur_b = {16'hFFFF, 16'hFFFF};
        run_start(1'b0, lat);
        check_eq("wide_value",  64'(out_value),  64'h1FFFC0002);
        check_eq("wide_index",  64'(out_index),  64'd7);
        check_eq("wide_action", 64'(out_action), 64'd3);
        retire();

        // Asynchronous reset mid-EVAL
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        check_eq("arst_busy",   64'(busy),       64'd0);
        check_eq("arst_valid",  64'(out_valid),  64'd0);
        check_eq("arst_done",   64'(done_pulse), 64'd0);
        check_eq("arst_action", 64'(out_action), 64'd0);
        check_eq("arst_index",  64'(out_index),  64'd0);
        check_eq("arst_value",  64'(out_value),  64'd0);
        step();
        rst_n = 1'b1;
        step();

        // Ragged batches: 10 vectors over 4 lanes
        for (int i = 0; i < 10; i++) begin
            alpha_g[i][0] = 16'(i);
            alpha_g[i][1] = 16'(i);
            pa_g[i]       = 2'(i % 4);
        end
        cur_b_g = {16'd1, 16'd1};
        run_start(1'b1, lat);
        check_eq("rag_latency", 64'(lat),          64'd4);
        check_eq("rag_index",   64'(out_index_g),  64'd9);
        check_eq("rag_value",   64'(out_value_g),  64'd18);
        check_eq("rag_action",  64'(out_action_g), 64'd1);
        check_eq("rag_done",    64'(done_pulse_g), 64'd1);
        out_ready_g = 1'b1;
        step();
        out_ready_g = 1'b0;
        check_eq("rag_retire",  64'(busy_g),       64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
